// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle MIPS-style 32-bit core on one unified req/ack memory port.
// Sequence: IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, plus HALT.
// Ports:
//   clk, rstd       clock (rising edge), asynchronous active-low reset
//   mem_req/mem_we  request (held until ack) and write strobe
//   mem_addr        word-aligned byte address, ADDR_W bits
//   mem_wdata       store data
//   mem_rdata       read data, sampled on the edge where mem_req & mem_ack
//   mem_ack         transfer complete (same-cycle ack allowed)
//   pc_out          address of the instruction in progress
//   halted          set once a halt instruction retires
module cpu_mc #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rstd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] pc, pc_d;
    logic [31:0]       ir, ir_d;
    logic [31:0]       a, a_d, b, b_d;
    logic [31:0]       wb, wb_d;
    logic [31:0]       rf [32];

    logic              rf_we;
    logic [4:0]        rf_wa;
    logic              req_d, we_d, halted_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       wdata_d;

    // Instruction fields, always taken from the latched ir
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] simm;
    assign op    = ir[31:26];
    assign funct = ir[5:0];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign simm  = {{16{ir[15]}}, ir[15:0]};

    // Address arithmetic, all modulo 2^ADDR_W
    logic [ADDR_W-1:0] pc4, btarget, jtarget, maddr;
    assign pc4     = pc + ADDR_W'(4);
    assign btarget = pc4 + ADDR_W'({simm[29:0], 2'b00});
    assign maddr   = ADDR_W'(a + simm) & ~ADDR_W'(3);

    // Jump target: {pc4 upper nibble, ins[25:0], 00} truncated to ADDR_W
    always_comb begin
        jtarget = '0;
        for (int i = 2; i < int'(ADDR_W); i++) begin
            jtarget[i] = (i < 28) ? ir[i-2] : pc4[i];
        end
    end

    // R-type ALU; unsupported funct codes are treated as nop
    logic [31:0] alu_r;
    logic        funct_ok;
    always_comb begin
        alu_r    = '0;
        funct_ok = 1'b1;
        case (funct)
            FN_ADD:  alu_r = a + b;
            FN_SUB:  alu_r = a - b;
            FN_AND:  alu_r = a & b;
            FN_OR:   alu_r = a | b;
            FN_SLT:  alu_r = {31'b0, $signed(a) < $signed(b)};
            default: funct_ok = 1'b0;
        endcase
    end

    // Next-state, datapath and next-output logic
    always_comb begin
        state_d = state;
        pc_d    = pc;
        ir_d    = ir;
        a_d     = a;
        b_d     = b;
        wb_d    = wb;
        rf_we   = 1'b0;
        rf_wa   = '0;

        case (state)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = (rs == 5'd0) ? 32'd0 : rf[rs];
                b_d     = (rt == 5'd0) ? 32'd0 : rf[rt];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op)
                    OP_R: begin
                        if (funct_ok) begin
                            wb_d    = alu_r;
                            state_d = S_WB;
                        end else begin
                            pc_d    = pc4;
                            state_d = S_FETCH;
                        end
                    end
                    OP_ADDI: begin
                        wb_d    = a + simm;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: state_d = S_MEM;
                    OP_BEQ: begin
                        pc_d    = (a == b) ? btarget : pc4;
                        state_d = S_FETCH;
                    end
                    OP_J: begin
                        pc_d    = jtarget;
                        state_d = S_FETCH;
                    end
                    OP_HALT: state_d = S_HALT;
                    default: begin
                        pc_d    = pc4;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (op == OP_SW) begin
                        pc_d    = pc4;
                        state_d = S_FETCH;
                    end else begin
                        wb_d    = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                rf_wa   = (op == OP_R) ? rd : rt;
                pc_d    = pc4;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state, so they are valid for the
        // whole cycle the FSM sits in FETCH/MEM and cannot move during waits.
        req_d    = (state_d == S_FETCH) || (state_d == S_MEM);
        we_d     = (state_d == S_MEM) && (op == OP_SW);
        addr_d   = '0;
        wdata_d  = '0;
        if (state_d == S_FETCH) addr_d = pc_d;
        if (state_d == S_MEM)   addr_d = maddr;
        if (we_d)               wdata_d = b_d;
        halted_d = (state_d == S_HALT);
    end

    // State, datapath, register file and output registers
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state     <= S_IDLE;
            pc        <= ADDR_W'(RESET_PC);
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            wb        <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            halted    <= 1'b0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            ir        <= ir_d;
            a         <= a_d;
            b         <= b_d;
            wb        <= wb_d;
            mem_req   <= req_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            halted    <= halted_d;
            if (rf_we && (rf_wa != 5'd0)) rf[rf_wa] <= wb;
        end
    end

    assign pc_out = pc;

endmodule

// File: tb/tb_cpu_mc.sv
// Self-checking bench for cpu_mc: behavioural memory with programmable wait
// states, a scoreboard of expected memory transfers, and directed programs.
module tb_cpu_mc;

    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned RESET_PC = 32'h40;

    logic              clk;
    logic              rstd;
    logic              mem_req, mem_we, mem_ack, halted;
    logic [ADDR_W-1:0] mem_addr, pc_out;
    logic [31:0]       mem_wdata, mem_rdata;

    cpu_mc #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .rstd      (rstd),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .pc_out    (pc_out),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: 64 words, ack after wait_n cycles of request
    logic [31:0] mem [64];
    int unsigned wait_n;
    int unsigned wcnt;
    logic        rand_mode, rand_bit;

    assign mem_rdata = mem[mem_addr[7:2]];
    always_comb mem_ack = rand_mode ? rand_bit : (mem_req && (wcnt >= wait_n));

    initial wcnt = 0;
    always @(posedge clk) begin
        if (!mem_req || mem_ack) wcnt <= 0;
        else                     wcnt <= wcnt + 1;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Scoreboard of expected transfers
    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
    } xfer_t;
    xfer_t exp_q[$];

    task automatic exp_rd(input logic [7:0] a);
        xfer_t x;
        x.we = 1'b0; x.addr = a; x.data = '0;
        exp_q.push_back(x);
    endtask

    task automatic exp_wr(input logic [7:0] a, input logic [31:0] d);
        xfer_t x;
        x.we = 1'b1; x.addr = a; x.data = d;
        exp_q.push_back(x);
    endtask

    // Monitor: checks every completed transfer and request stability across waits
    initial begin
        logic [40:0] cur, saved;
        logic        held, unstable, waited;
        xfer_t       e;
        held = 0; unstable = 0; waited = 0; saved = '0;
        forever begin
            @(negedge clk);
            if (rstd && mem_req) begin
                cur = {mem_we, mem_addr, mem_wdata};
                if (held && cur != saved) unstable = 1;
                if (!held) begin
                    saved = cur; held = 1; waited = 0;
                end else begin
                    waited = 1;
                end
                if (mem_ack) begin
                    if (waited) check("req_stable", 32'(unstable), 0);
                    check("sb_has_entry", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("xfer_we", 32'(mem_we), 32'(e.we));
                        check("xfer_addr", 32'(mem_addr), 32'(e.addr));
                        if (e.we) check("xfer_wdata", mem_wdata, e.data);
                    end
                    if (mem_we) mem[mem_addr[7:2]] = mem_wdata;
                    held = 0; unstable = 0;
                end
            end else begin
                held = 0; unstable = 0;
            end
        end
    end

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic put(input logic [7:0] a, input logic [31:0] w);
        mem[a[7:2]] = w;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = '0;
    endtask

    task automatic wait_req(input int max, output int at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk); #2;
            if (mem_req) begin at = cyc; break; end
        end
        if (at < 0) check("req_timeout", 32'(mem_req), 1);
    endtask

    task automatic wait_halted(input int max, output int at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk); #2;
            if (halted) begin at = cyc; break; end
        end
        if (at < 0) check("halt_timeout", 32'(halted), 1);
    endtask

    task automatic wait_drain(input int max);
        for (int i = 0; i < max; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk); #2;
        end
        check("sb_drained", 32'(exp_q.size()), 0);
    endtask

    task automatic load_arith();
        put(8'h40, enc_i(6'h08, 0, 1, 16'd5));
        put(8'h44, enc_i(6'h08, 0, 2, 16'hFFFD));
        put(8'h48, enc_r(1, 2, 3, 6'h20));
        put(8'h4C, enc_r(2, 1, 4, 6'h2A));
    endtask

    initial begin
        int t0, t1, found;
        rstd = 1'b0; rand_mode = 1'b0; rand_bit = 1'b0; wait_n = 0;

        // Phase 1: arithmetic program, zero-wait latency, then halt behaviour
        clear_mem();
        load_arith();
        put(8'h50, {6'h3F, 26'd0});
        repeat (2) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_pc_out", 32'(pc_out), 32'h40);
        for (int k = 0; k < 5; k++) exp_rd(8'(32'h40 + 4 * k));
        rstd = 1'b1;
        wait_req(20, t0);
        check("first_fetch_addr", 32'(mem_addr), 32'h40);
        check("first_fetch_pc", 32'(pc_out), 32'h40);
        wait_halted(200, t1);
        check("arith_latency", 32'(t1 - t0), 19);
        check("sb_empty_arith", 32'(exp_q.size()), 0);

        rand_mode = 1'b1;
        for (int k = 0; k < 50; k++) begin
            rand_bit = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("halt_hold", 32'({mem_req, halted, pc_out}), 32'({1'b0, 1'b1, 8'h50}));
        end
        rand_mode = 1'b0;
        rand_bit  = 1'b0;

        // Phase 2: loads/stores with 3 wait cycles per transfer
        rstd = 1'b0;
        #1;
        check("halt_cleared_by_rst", 32'(halted), 0);
        wait_n = 3;
        clear_mem();
        load_arith();
        put(8'h50, enc_i(6'h2B, 0, 3, 16'd8));       // sw  $3,8($0)
        put(8'h54, enc_i(6'h23, 0, 5, 16'd8));       // lw  $5,8($0)
        put(8'h58, enc_i(6'h2B, 0, 5, 16'd12));      // sw  $5,12($0)
        put(8'h5C, enc_r(2, 1, 6, 6'h22));           // sub $6,$2,$1
        put(8'h60, enc_r(1, 2, 7, 6'h24));           // and $7,$1,$2
        put(8'h64, enc_r(1, 2, 8, 6'h25));           // or  $8,$1,$2
        put(8'h68, enc_r(1, 2, 9, 6'h2A));           // slt $9,$1,$2
        put(8'h6C, enc_i(6'h2B, 0, 4, 16'd16));
        put(8'h70, enc_i(6'h2B, 0, 6, 16'd20));
        put(8'h74, enc_i(6'h2B, 0, 7, 16'd24));
        put(8'h78, enc_i(6'h2B, 0, 8, 16'd28));
        put(8'h7C, enc_i(6'h2B, 0, 9, 16'd32));
        put(8'h80, enc_i(6'h2B, 1, 3, 16'hFFFC));    // sw $3,-4($1): addr 1 -> 0
        put(8'h84, {6'h3F, 26'd0});
        for (int k = 0; k < 5; k++) exp_rd(8'(32'h40 + 4 * k));
        exp_wr(8'h08, 32'd2);
        exp_rd(8'h54); exp_rd(8'h08);
        exp_rd(8'h58); exp_wr(8'h0C, 32'd2);
        exp_rd(8'h5C); exp_rd(8'h60); exp_rd(8'h64); exp_rd(8'h68);
        exp_rd(8'h6C); exp_wr(8'h10, 32'd1);
        exp_rd(8'h70); exp_wr(8'h14, 32'hFFFF_FFF8);
        exp_rd(8'h74); exp_wr(8'h18, 32'd5);
        exp_rd(8'h78); exp_wr(8'h1C, 32'hFFFF_FFFD);
        exp_rd(8'h7C); exp_wr(8'h20, 32'd0);
        exp_rd(8'h80); exp_wr(8'h00, 32'd2);
        exp_rd(8'h84);
        @(negedge clk);
        rstd = 1'b1;
        wait_halted(2000, t1);
        check("sb_empty_mem", 32'(exp_q.size()), 0);

        // Phase 3: $0 handling, unknown opcode, jump truncation, wrap, branches
        rstd = 1'b0;
        wait_n = 2;
        clear_mem();
        put(8'h40, enc_i(6'h08, 0, 0, 16'd7));       // addi $0,$0,7
        put(8'h44, enc_r(0, 0, 6, 6'h20));           // add  $6,$0,$0
        put(8'h48, enc_i(6'h2B, 0, 6, 16'd20));      // sw   $6,20($0)
        put(8'h4C, {6'h3E, 5'd0, 5'd7, 16'd9});      // unknown opcode
        put(8'h50, enc_i(6'h2B, 0, 7, 16'd24));      // sw   $7,24($0)
        put(8'h54, {6'h02, 26'h0FF});                // j 0x3FC -> 0xFC
        put(8'h58, enc_i(6'h2B, 0, 0, 16'd28));      // must be skipped
        put(8'hFC, enc_i(6'h08, 0, 1, 16'd1));       // addi $1,$0,1 ; wraps to 0
        put(8'h00, enc_i(6'h04, 1, 1, 16'd1));       // beq taken -> 0x08
        put(8'h04, enc_i(6'h2B, 0, 1, 16'd28));      // must be skipped
        put(8'h08, enc_i(6'h04, 1, 0, 16'd5));       // beq not taken
        put(8'h0C, 32'd0);                           // nop
        put(8'h10, enc_i(6'h04, 1, 1, 16'hFFFF));    // beq $1,$1,-1 (loop)
        exp_rd(8'h40); exp_rd(8'h44); exp_rd(8'h48); exp_wr(8'h14, 32'd0);
        exp_rd(8'h4C); exp_rd(8'h50); exp_wr(8'h18, 32'd0);
        exp_rd(8'h54); exp_rd(8'hFC); exp_rd(8'h00); exp_rd(8'h08);
        exp_rd(8'h0C); exp_rd(8'h10); exp_rd(8'h10); exp_rd(8'h10);
        @(negedge clk);
        rstd = 1'b1;
        wait_drain(1000);

        // Reset in the middle of a waiting fetch
        found = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #2;
            if (mem_req && !mem_ack) begin found = 1; break; end
        end
        check("midfetch_found", 32'(found), 1);
        rstd = 1'b0;
        #1;
        check("midrst_mem_req", 32'(mem_req), 0);
        check("midrst_mem_we", 32'(mem_we), 0);
        check("midrst_mem_addr", 32'(mem_addr), 0);
        check("midrst_pc_out", 32'(pc_out), 32'h40);
        exp_rd(8'h40);
        @(negedge clk);
        rstd = 1'b1;
        wait_req(20, t0);
        check("refetch_addr", 32'(mem_addr), 32'h40);
        check("refetch_pc", 32'(pc_out), 32'h40);
        wait_drain(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
